mul_issue_arbiter: RTL and testbench

//  Shares one 3-stage multiplier (16x16 saturating, 2-cycle issue-to-result,
//  no reset, no stall) between NUM_REQ requesters. Round-robin grant of one
//  op per cycle. Tracks each in-flight op's owner in a 2-deep tag pipe and

---
 rtl/mul_issue_arbiter.sv | 143 ++++++++++++++
 tb/tb_mul_issue_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter
// Round-robin front end for one shared 3-stage saturating multiplier.
// One op is granted per cycle. A 2-deep tag pipe follows each op through
// the multiplier so that its result goes back to the requester that issued it.
// The multiplier has no reset and no stall. The tag pipe is the only record
// of which multiplier slots hold live work. The multiplier's busy flags are
// cross-checked against it once stale contents have drained.

module mul_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_en,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_instr,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [15:0]            mul_instr,
  output logic [15:0]            mul_a,
  output logic [15:0]            mul_b,
  input  logic [1:0]             mul_status,
  input  logic [15:0]            mul_instr_ex,
  input  logic [15:0]            mul_product,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [15:0]            rsp_instr,
  output logic [15:0]            rsp_product,
  output logic [1:0]             inflight,
  output logic                   idle,
  output logic                   seq_err
);

  // Cycles during which the multiplier may still hold ops the tags no longer track
  localparam logic [1:0] WARMUP = 2'd2;

  logic [NUM_REQ-1:0] elig;
  logic [IDW-1:0]     rr_ptr;
  logic               gnt_v;
  logic [IDW-1:0]     gnt_id;
  logic               t1_v;
  logic [IDW-1:0]     t1_id;
  logic               t2_v;
  logic [IDW-1:0]     t2_id;
  logic [1:0]         chk_cnt;
  logic               chk_en;

  // A requester competes only with a non-bubble instr while issue is open
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & (|req_instr[16*i +: 16]) & issue_en;
    end
  end

  // Round-robin scan: first eligible requester at or after rr_ptr
  always_comb begin
    logic [IDW-1:0] idx;
    idx    = '0;
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_v && elig[idx]) begin
        gnt_v  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  // One-hot ready and operand steering. Without a grant the multiplier sees a bubble.
  always_comb begin
    req_ready = '0;
    mul_instr = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_v && (gnt_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mul_instr    = req_instr[16*i +: 16];
        mul_a        = req_a[16*i +: 16];
        mul_b        = req_b[16*i +: 16];
      end
    end
  end

  // Priority pointer moves just past the last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_v) begin
      rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Tag pipe mirrors the multiplier stages. A flush kills the older tags, but the grant made in the flush cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_v  <= 1'b0;
      t1_id <= '0;
      t2_v  <= 1'b0;
      t2_id <= '0;
    end else begin
      t1_v  <= gnt_v;
      t1_id <= gnt_id;
      t2_v  <= t1_v & ~flush;
      t2_id <= t1_id;
    end
  end

  // Down-counter masking the status check while stale multiplier contents drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt <= WARMUP;
    end else if (flush) begin
      chk_cnt <= WARMUP;
    end else if (chk_cnt != 2'd0) begin
      chk_cnt <= chk_cnt - 2'd1;
    end
  end

  assign chk_en = (chk_cnt == 2'd0);

  // Sticky flag for any disagreement between the tags and the multiplier busy bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
    end else if (chk_en && ((t1_v != mul_status[1]) || (t2_v != mul_status[0]))) begin
      seq_err <= 1'b1;
    end
  end

  assign rsp_valid   = t2_v & ~flush;
  assign rsp_id      = t2_id;
  assign rsp_instr   = mul_instr_ex;
  assign rsp_product = mul_product;
  assign inflight    = {1'b0, t1_v} + {1'b0, t2_v};
  assign idle        = (inflight == 2'd0) & ~(|req_valid);

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Bench for mul_issue_arbiter: a behavioural multiplier drives the arbiter,
// and a scoreboard queue of expected responses predicts every output.
module tb_mul_issue_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_en;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_instr;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [15:0]     mul_instr;
  logic [15:0]     mul_a;
  logic [15:0]     mul_b;
  logic [1:0]      mul_status;
  logic [15:0]     mul_instr_ex;
  logic [15:0]     mul_product;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_instr;
  logic [15:0]     rsp_product;
  logic [1:0]      inflight;
  logic            idle;
  logic            seq_err;

  always #5 clk = ~clk;

  mul_issue_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_a(req_a), .req_b(req_b), .mul_instr(mul_instr), .mul_a(mul_a),
    .mul_b(mul_b), .mul_status(mul_status), .mul_instr_ex(mul_instr_ex),
    .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_instr(rsp_instr), .rsp_product(rsp_product), .inflight(inflight),
    .idle(idle), .seq_err(seq_err)
  );

  function automatic logic [15:0] sat_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'b0, a} * {16'b0, b};
    return (p > 32'h0000_FFFF) ? 16'hFFFF : p[15:0];
  endfunction

  // Behavioural multiplier: no reset, 2 cycles from issue to result
  logic [15:0] s1_i = '0, s1_a = '0, s1_b = '0, s2_i = '0, s2_p = '0;
  logic        force_st = 1'b0;
  logic [1:0]  force_val = 2'b00;
  always @(posedge clk) begin
    s1_i <= mul_instr;
    s1_a <= mul_a;
    s1_b <= mul_b;
    s2_i <= s1_i;
    s2_p <= sat_mul(s1_a, s1_b);
  end
  assign mul_instr_ex = s2_i;
  assign mul_product  = s2_p;
  assign mul_status   = force_st ? force_val : {|s1_i, |s2_i};

  // Scoreboard
  typedef struct {
    int          due;
    int          id;
    logic [15:0] instr;
    logic [15:0] prod;
  } exp_t;
  exp_t q[$];
  int   rr, cyc, since_rel, since_flush;
  bit   exp_seq;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] s_ready;
  logic         s_rsp_valid, s_seq;
  logic [IDW-1:0] s_rsp_id;
  logic [15:0]  s_rsp_product, s_rsp_instr;
  logic [1:0]   s_inflight;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_seq     = 1'b0;
    rr          = 0;
    since_rel   = 0;
    since_flush = 100;
  endtask

  task automatic clr();
    req_valid = '0;
    req_instr = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic drive(input int i, input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]        = 1'b1;
    req_instr[16*i+:16] = ins;
    req_a[16*i+:16]     = a;
    req_b[16*i+:16]     = b;
  endtask

  // One cycle: inputs are already set after the posedge. Check at the negedge, then advance the model.
  task automatic step();
    int          g, idx;
    logic [N-1:0] er;
    logic [15:0] ei, ea, eb;
    bit          t1, t2, ev;
    logic [1:0]  st;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (g < 0 && issue_en && req_valid[idx] && req_instr[16*idx+:16] != 16'h0) g = idx;
    end
    er = '0; ei = '0; ea = '0; eb = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ei = req_instr[16*g+:16];
      ea = req_a[16*g+:16];
      eb = req_b[16*g+:16];
    end
    t2 = (q.size() > 0) && (q[0].due == cyc);
    t1 = (q.size() > 0) && (q[q.size()-1].due == cyc + 1);
    ev = t2 && !flush;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("mul_instr", 32'(mul_instr), 32'(ei));
    chk("mul_a", 32'(mul_a), 32'(ea));
    chk("mul_b", 32'(mul_b), 32'(eb));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_instr", 32'(rsp_instr), 32'(q[0].instr));
      chk("rsp_product", 32'(rsp_product), 32'(q[0].prod));
    end
    chk("inflight", 32'(inflight), 32'(int'(t1) + int'(t2)));
    chk("idle", 32'(idle), 32'((!t1 && !t2 && req_valid == '0)));
    chk("seq_err", 32'(seq_err), 32'(exp_seq));
    s_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_id = rsp_id;
    s_rsp_product = rsp_product; s_rsp_instr = rsp_instr;
    s_inflight = inflight; s_seq = seq_err;
    st = mul_status;
    if (since_rel >= 2 && since_flush >= 3 && (t1 != st[1] || t2 != st[0])) exp_seq = 1'b1;
    if (flush) q.delete();
    else if (t2) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{due: cyc + 2, id: g, instr: ei, prod: sat_mul(ea, eb)});
      rr = (g + 1) % N;
    end
    cyc++;
    since_rel++;
    since_flush = flush ? 1 : since_flush + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0;
    issue_en = 1'b1;
    flush = 1'b0;
    clr();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step();

    // Basic op: 3*5
    drive(0, 16'h0011, 16'd3, 16'd5);
    step();
    chk("t1_ready", 32'(s_ready), 32'h1);
    clr(); step(); step();
    chk("t1_rsp_valid", 32'(s_rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(s_rsp_id), 32'd0);
    chk("t1_rsp_product", 32'(s_rsp_product), 32'd15);
    chk("t1_rsp_instr", 32'(s_rsp_instr), 32'h0011);

    // Saturation, issued from req3 so the pointer wraps to 0
    drive(3, 16'h0022, 16'h0100, 16'h0100);
    step(); clr(); step(); step();
    chk("t2_rsp_product", 32'(s_rsp_product), 32'hFFFF);
    chk("t2_rsp_id", 32'(s_rsp_id), 32'd3);

    // All four requesters held valid for 8 cycles
    for (int i = 0; i < N; i++) drive(i, 16'h0030 + 16'(i), 16'(i + 1), 16'd7);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t3_grant", 32'(s_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("t3_inflight", 32'(s_inflight), 32'd2);
        chk("t3_rsp_id", 32'(s_rsp_id), 32'((k - 2) % 4));
      end
    end
    clr(); step(); step();

    // Pointer at 2 with req1 and req3 pending; req0 has a zero instr
    drive(1, 16'h0041, 16'd2, 16'd2);
    step(); clr();
    drive(0, 16'h0000, 16'd9, 16'd9);
    drive(1, 16'h0042, 16'd4, 16'd4);
    drive(3, 16'h0043, 16'd6, 16'd6);
    step();
    chk("t4_first", 32'(s_ready), 32'h8);
    req_valid[3] = 1'b0;
    step();
    chk("t4_second", 32'(s_ready), 32'h2);
    req_valid[1] = 1'b0;
    step();
    chk("t4_zero_instr", 32'(s_ready), 32'h0);
    clr(); step(); step();

    // Flush with two ops in flight
    drive(0, 16'h0051, 16'd5, 16'd5); step(); clr();
    drive(1, 16'h0052, 16'd6, 16'd6); step(); clr();
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_flush_rsp", 32'(s_rsp_valid), 32'd0);
    step();
    chk("t5_inflight", 32'(s_inflight), 32'd0);
    chk("t5_no_rsp", 32'(s_rsp_valid), 32'd0);
    repeat (3) step();
    chk("t5_seq_err", 32'(s_seq), 32'd0);

    // Asynchronous reset in the middle of a cycle with two ops in flight
    drive(0, 16'h0061, 16'd7, 16'd7); step(); clr();
    drive(2, 16'h0062, 16'd8, 16'd8); step(); clr();
    chk("t6_pre_inflight", 32'(inflight), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_inflight", 32'(inflight), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(); step();
    force_st = 1'b1; force_val = 2'b11;
    step();
    force_st = 1'b0;
    step();
    chk("t6_seq_err_set", 32'(s_seq), 32'd1);
    step();
    chk("t6_seq_err_sticky", 32'(s_seq), 32'd1);

    // Reset again, then random traffic
    rst_n = 1'b0;
    #1;
    chk("rst2_seq_err", 32'(seq_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      issue_en = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i]        = ($urandom_range(0, 2) != 0);
        req_instr[16*i+:16] = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
        req_a[16*i+:16]     = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
        req_b[16*i+:16]     = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      end
      step();
    end
    flush = 1'b0;
    clr();
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
